// File: rtl/hazard_tracker.sv
// hazard_tracker: tracks micro-ops through EX/MEM/WB, detects RAW hazards
// for the ID instruction, raises load-use stall and registers EX forward selects.

// Per-source forwarding lane: one instance per ID source operand.
module hazard_fwd_lane (
   input  logic [4:0] src,
   input  logic       use_src,
   input  logic       ex_wr,
   input  logic [4:0] ex_dst,
   input  logic       mem_wr,
   input  logic [4:0] mem_dst,
   output logic       ex_hit,
   output logic [1:0] sel
);
   logic live, mem_hit;

   // r0 and unread sources never match; EX beats MEM
   always_comb begin
      live    = use_src & (src != 5'd0);
      ex_hit  = live & ex_wr  & (ex_dst  == src);
      mem_hit = live & mem_wr & (mem_dst == src);
      sel     = ex_hit ? 2'b01 : (mem_hit ? 2'b10 : 2'b00);
   end
endmodule

module hazard_tracker #(
   parameter int STALL_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   id_valid,
   input  logic [10:0]            id_micro,
   input  logic [4:0]             id_rs,
   input  logic [4:0]             id_rt,
   input  logic                   id_use_rs,
   input  logic                   id_use_rt,
   input  logic                   flush,
   output logic                   stall,
   output logic [1:0]             fwd_a,
   output logic [1:0]             fwd_b,
   output logic [10:0]            ex_micro,
   output logic [10:0]            mem_micro,
   output logic [10:0]            wb_micro,
   output logic                   ex_valid,
   output logic                   mem_valid,
   output logic                   wb_valid,
   output logic [STALL_CNT_W-1:0] stall_count
);
   // INS type codes (micro-coder encoding)
   localparam logic [5:0] INS_NOP  = 6'd0,
                          INS_ADD  = 6'd1,  INS_ADDU  = 6'd2,  INS_SUB  = 6'd3,
                          INS_SUBU = 6'd4,  INS_AND   = 6'd5,  INS_OR   = 6'd6,
                          INS_XOR  = 6'd7,  INS_NOR   = 6'd8,  INS_SLT  = 6'd9,
                          INS_SLTU = 6'd10, INS_SLL   = 6'd11, INS_SRL  = 6'd12,
                          INS_SRA  = 6'd13, INS_SLLV  = 6'd14, INS_SRLV = 6'd15,
                          INS_SRAV = 6'd16, INS_ADDI  = 6'd17, INS_ADDIU= 6'd18,
                          INS_ANDI = 6'd19, INS_ORI   = 6'd20, INS_XORI = 6'd21,
                          INS_SLTI = 6'd22, INS_SLTIU = 6'd23, INS_LUI  = 6'd24,
                          INS_LB   = 6'd25, INS_LH    = 6'd26, INS_LBU  = 6'd27,
                          INS_LHU  = 6'd28, INS_LW    = 6'd29, INS_SB   = 6'd30,
                          INS_SH   = 6'd31, INS_SW    = 6'd32, INS_BEQ  = 6'd33,
                          INS_BNE  = 6'd34, INS_BLEZ  = 6'd35, INS_BGTZ = 6'd36,
                          INS_BLTZ = 6'd37, INS_BGEZ  = 6'd38, INS_J    = 6'd39,
                          INS_JAL  = 6'd40, INS_JR    = 6'd41, INS_JALR = 6'd42;

   localparam int STAGES  = 3;   // 1=EX 2=MEM 3=WB
   localparam int NUM_SRC = 2;   // 0=rs/A 1=rt/B
   localparam logic [10:0] BUBBLE = {INS_NOP, 5'd0};

   function automatic logic is_load(input logic [5:0] ins);
      return ins inside {INS_LB, INS_LH, INS_LBU, INS_LHU, INS_LW};
   endfunction

   // Anything not listed (branches, J, JR, stores, NOP, unknown) never writes
   function automatic logic is_writer(input logic [5:0] ins);
      return is_load(ins) ||
             ins inside {INS_ADD, INS_ADDU, INS_SUB, INS_SUBU, INS_AND, INS_OR,
                         INS_XOR, INS_NOR, INS_SLT, INS_SLTU, INS_SLL, INS_SRL,
                         INS_SRA, INS_SLLV, INS_SRLV, INS_SRAV, INS_ADDI,
                         INS_ADDIU, INS_ANDI, INS_ORI, INS_XORI, INS_SLTI,
                         INS_SLTIU, INS_LUI, INS_JAL, INS_JALR};
   endfunction

   logic [STAGES:1]                vld_pipe;
   logic [STAGES:1][10:0]          micro_pipe;
   logic [NUM_SRC-1:0][4:0]        src;
   logic [NUM_SRC-1:0]             use_src, ex_hit;
   logic [NUM_SRC-1:0][1:0]        sel, fwd_q;
   logic                           ex_wr, mem_wr, bubble;

   assign src     = {id_rt, id_rs};
   assign use_src = {id_use_rt, id_use_rs};
   assign ex_wr   = vld_pipe[1] & is_writer(micro_pipe[1][10:5]);
   assign mem_wr  = vld_pipe[2] & is_writer(micro_pipe[2][10:5]);

   genvar g;
   generate
      for (g = 0; g < NUM_SRC; g++) begin : g_lane
         hazard_fwd_lane u_lane (
            .src     (src[g]),
            .use_src (use_src[g]),
            .ex_wr   (ex_wr),
            .ex_dst  (micro_pipe[1][4:0]),
            .mem_wr  (mem_wr),
            .mem_dst (micro_pipe[2][4:0]),
            .ex_hit  (ex_hit[g]),
            .sel     (sel[g])
         );
      end
   endgenerate

   // Load in EX feeding either ID source; flush overrides
   assign stall  = id_valid & ~flush & is_load(micro_pipe[1][10:5]) & (|ex_hit);
   assign bubble = stall | flush;

   // Stage advance: MEM/WB always shift, EX takes ID or a bubble
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_pipe   <= '0;
         micro_pipe <= {STAGES{BUBBLE}};
         fwd_q      <= '0;
      end else begin
         vld_pipe[STAGES:2]   <= vld_pipe[STAGES-1:1];
         micro_pipe[STAGES:2] <= micro_pipe[STAGES-1:1];
         if (bubble) begin
            vld_pipe[1]   <= 1'b0;
            micro_pipe[1] <= BUBBLE;
            fwd_q         <= '0;
         end else begin
            vld_pipe[1]   <= id_valid;
            micro_pipe[1] <= id_micro;
            fwd_q         <= sel;
         end
      end
   end

   // Saturating count of stall cycles
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         stall_count <= '0;
      else if (stall && (stall_count != {STALL_CNT_W{1'b1}}))
         stall_count <= stall_count + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
   end

   assign fwd_a     = fwd_q[0];
   assign fwd_b     = fwd_q[1];
   assign ex_valid  = vld_pipe[1];
   assign mem_valid = vld_pipe[2];
   assign wb_valid  = vld_pipe[3];
   assign ex_micro  = micro_pipe[1];
   assign mem_micro = micro_pipe[2];
   assign wb_micro  = micro_pipe[3];
endmodule

// File: tb/tb_hazard_tracker.sv
// Directed bench for hazard_tracker; a second instance with a 2-bit counter
// shares all stimulus to exercise counter saturation.
module tb_hazard_tracker;
   localparam logic [5:0] ADD = 6'd1,  SUB = 6'd3,  OR_ = 6'd6,  XOR_ = 6'd7,
                          SLT = 6'd9,  ADDI = 6'd17, ORI = 6'd20, LUI = 6'd24,
                          LH  = 6'd26, LW  = 6'd29,  SW  = 6'd32, J    = 6'd39;

   logic        clk = 1'b0, rst_n = 1'b0;
   logic        id_valid = 0, id_use_rs = 0, id_use_rt = 0, flush = 0;
   logic [10:0] id_micro = '0;
   logic [4:0]  id_rs = '0, id_rt = '0;
   logic        stall, ex_valid, mem_valid, wb_valid;
   logic [1:0]  fwd_a, fwd_b;
   logic [10:0] ex_micro, mem_micro, wb_micro;
   logic [15:0] stall_count;
   logic        stall2, ex_valid2, mem_valid2, wb_valid2;
   logic [1:0]  fwd_a2, fwd_b2;
   logic [10:0] ex_micro2, mem_micro2, wb_micro2;
   logic [1:0]  stall_count2;
   int          checks = 0, errors = 0;

   always #5 clk = ~clk;

   hazard_tracker #(.STALL_CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_micro(id_micro),
      .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
      .flush(flush), .stall(stall), .fwd_a(fwd_a), .fwd_b(fwd_b),
      .ex_micro(ex_micro), .mem_micro(mem_micro), .wb_micro(wb_micro),
      .ex_valid(ex_valid), .mem_valid(mem_valid), .wb_valid(wb_valid),
      .stall_count(stall_count));

   hazard_tracker #(.STALL_CNT_W(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_micro(id_micro),
      .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
      .flush(flush), .stall(stall2), .fwd_a(fwd_a2), .fwd_b(fwd_b2),
      .ex_micro(ex_micro2), .mem_micro(mem_micro2), .wb_micro(wb_micro2),
      .ex_valid(ex_valid2), .mem_valid(mem_valid2), .wb_valid(wb_valid2),
      .stall_count(stall_count2));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive ID; inputs change 1 time unit after the rising edge
   task automatic id(input logic v, input logic [5:0] ins, input logic [4:0] rd,
                     input logic [4:0] rs, input logic [4:0] rt,
                     input logic urs, input logic urt);
      id_valid = v; id_micro = {ins, rd}; id_rs = rs; id_rt = rt;
      id_use_rs = urs; id_use_rt = urt;
   endtask

   task automatic idle();
      id(1'b0, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
   endtask

   // Advance one edge and settle past it
   task automatic tick();
      @(posedge clk); #1;
   endtask

   initial begin
      // reset state
      #2;
      chk("rst_stall", stall, 0);
      chk("rst_ex_valid", ex_valid, 0);
      chk("rst_ex_micro", ex_micro, 0);
      chk("rst_fwd", {fwd_a, fwd_b}, 0);
      chk("rst_count", stall_count, 0);
      @(negedge clk); rst_n = 1'b1;
      tick();

      // ADD r5 -> SUB rs=5: EX forward on A
      id(1, ADD, 5, 1, 2, 1, 1); #2;
      chk("add_stall", stall, 0);
      tick();
      id(1, SUB, 6, 5, 7, 1, 1); #2;
      chk("sub_stall", stall, 0);
      chk("add_in_ex", ex_micro, {ADD, 5'd5});
      tick();
      idle(); #2;
      chk("sub_fwd_a", fwd_a, 2'b01);
      chk("sub_fwd_b", fwd_b, 2'b00);
      chk("sub_in_ex", ex_micro, {SUB, 5'd6});
      chk("add_in_mem", mem_micro, {ADD, 5'd5});
      tick(); #2;
      chk("add_in_wb", wb_micro, {ADD, 5'd5});
      chk("wb_valid", wb_valid, 1);
      chk("idle_ex_valid", ex_valid, 0);
      tick();

      // LW r8 -> ADD rs=8: one stall, then MEM forward
      id(1, LW, 8, 0, 0, 0, 0); tick();
      id(1, ADD, 9, 8, 0, 1, 1); #2;
      chk("lu_stall_on", stall, 1);
      tick(); #2;
      chk("lu_stall_off", stall, 0);
      chk("lu_bubble_valid", ex_valid, 0);
      chk("lu_bubble_micro", ex_micro, 0);
      chk("lu_count1", stall_count, 1);
      tick();
      idle(); #2;
      chk("lu_add_ex", ex_micro, {ADD, 5'd9});
      chk("lu_fwd_a", fwd_a, 2'b10);
      chk("lu_fwd_b", fwd_b, 2'b00);
      tick();

      // r0 writer, then store with garbage destination
      id(1, ADDI, 0, 3, 3, 1, 0); tick();
      id(1, OR_, 1, 0, 0, 1, 1); #2;
      chk("r0_stall", stall, 0);
      tick();
      id(1, SW, 12, 0, 0, 0, 0); #2;
      chk("r0_fwd", {fwd_a, fwd_b}, 0);
      tick();
      id(1, ADD, 2, 12, 12, 1, 1); tick();
      idle(); #2;
      chk("sw_fwd", {fwd_a, fwd_b}, 0);
      tick();

      // ADD r3 in MEM, ORI r3 in EX: EX wins on both operands
      id(1, ADD, 3, 0, 0, 0, 0); tick();
      id(1, ORI, 3, 0, 0, 0, 0); tick();
      id(1, XOR_, 4, 3, 3, 1, 1); #2;
      chk("prio_stall", stall, 0);
      tick();
      idle(); #2;
      chk("prio_fwd_a", fwd_a, 2'b01);
      chk("prio_fwd_b", fwd_b, 2'b01);
      tick();

      // MEM forward on B only; A unused despite matching register
      id(1, LUI, 7, 0, 0, 0, 0); tick();
      id(1, J, 0, 0, 0, 0, 0); tick();
      id(1, SLT, 10, 7, 7, 0, 1); tick();
      idle(); #2;
      chk("mem_fwd_a", fwd_a, 2'b00);
      chk("mem_fwd_b", fwd_b, 2'b10);
      tick();

      // load-use with flush: flush wins
      id(1, LH, 11, 0, 0, 0, 0); tick();
      id(1, ADD, 13, 11, 0, 1, 0); flush = 1; #2;
      chk("flush_stall", stall, 0);
      tick();
      flush = 0; idle(); #2;
      chk("flush_bubble", ex_valid, 0);
      chk("flush_count", stall_count, 1);
      tick();

      // back-to-back loads: one stall per pair
      id(1, LW, 14, 0, 0, 0, 0); tick();
      id(1, LW, 15, 14, 0, 1, 0); #2;
      chk("b2b_stall1", stall, 1);
      tick(); #2;
      chk("b2b_stall1_off", stall, 0);
      tick();
      id(1, ADD, 16, 15, 0, 1, 0); #2;
      chk("b2b_lw_fwd_a", fwd_a, 2'b10);
      chk("b2b_stall2", stall, 1);
      tick(); #2;
      chk("b2b_stall2_off", stall, 0);
      chk("b2b_count", stall_count, 3);
      chk("sat_count_at3", stall_count2, 3);
      tick();

      // two more load-use stalls: narrow counter holds at 3
      for (int i = 0; i < 2; i++) begin
         id(1, LW, 17, 0, 0, 0, 0); tick();
         id(1, ADD, 18, 0, 17, 0, 1); tick();
         tick();
      end
      idle(); #2;
      chk("count5", stall_count, 5);
      chk("sat_count", stall_count2, 3);
      tick();

      // reset asserted mid-stall clears everything without a clock
      id(1, LW, 20, 0, 0, 0, 0); tick();
      id(1, ADD, 21, 20, 0, 1, 0); #2;
      chk("mid_stall_on", stall, 1);
      rst_n = 1'b0; #1;
      chk("mid_rst_stall", stall, 0);
      chk("mid_rst_valid", {ex_valid, mem_valid, wb_valid}, 0);
      chk("mid_rst_micro", {ex_micro, mem_micro, wb_micro}, 0);
      chk("mid_rst_count", stall_count, 0);
      chk("mid_rst_count2", stall_count2, 0);
      @(negedge clk); rst_n = 1'b1; idle();
      for (int i = 0; i < 4; i++) tick();
      #2;
      chk("post_rst_count", stall_count, 0);
      chk("post_rst_stall", stall, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/hazard_tracker.md
# hazard_tracker

Tracks the micro-instructions produced by the decode-stage micro-coder as they move through EX, MEM and WB. Each micro-instruction is 11 bits: {6-bit INS type, 5-bit destination register}. The block detects read-after-write hazards for the instruction in ID. It raises a one-cycle load-use stall and produces registered operand-forwarding selects that travel with the instruction into EX. It sits directly downstream of the micro-coder and feeds the ID/EX pipeline control and the EX operand muxes.

## Interface
Parameters:
- STALL_CNT_W, 16, width of the saturating stall counter.

Ports:
- clk  in  1  pipeline clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- id_valid  in  1  ID holds a real instruction this cycle.
- id_micro  in  11  micro-instruction from the micro-coder: [10:5] INS type, [4:0] destination register.
- id_rs  in  5  first source register of the ID instruction.
- id_rt  in  5  second source register of the ID instruction.
- id_use_rs  in  1  ID instruction reads rs.
- id_use_rt  in  1  ID instruction reads rt.
- flush  in  1  taken branch/jump resolved; kill the ID instruction.
- stall  out  1  combinational; hold PC and IF/ID, insert a bubble into EX.
- fwd_a  out  2  registered; EX operand A source: 00 register file, 01 MEM-stage result, 10 WB-stage result.
- fwd_b  out  2  registered; same encoding as fwd_a, for operand B.
- ex_micro, mem_micro, wb_micro  out  11 each  micro-instruction currently in each stage.
- ex_valid, mem_valid, wb_valid  out  1 each  stage holds a real instruction.
- stall_count  out  STALL_CNT_W  number of stall cycles since reset; saturates at its maximum value.

## Operation
- Writer classes, from the `INS_*` codes in tools/def.v:
  - Writer: all ALU R-type, shift, I-type ALU, LUI, load, JAL and JALR codes.
  - Non-writer: branch, J, JR, store and INS_NOP codes. Their destination field is x and is never compared.
- Load classes: INS_LB, INS_LH, INS_LBU, INS_LHU, INS_LW.
- Stage X matches source S when all of the following hold: X_valid, X is a writer, X destination equals S, S is not 0, and the matching id_use bit is 1.
- stall = id_valid & !flush & (EX is a load that matches rs or rt).
- Forwarding is computed in ID and registered into fwd_a/fwd_b when the instruction advances:
  - If EX matches the source: select 01. EX moves to MEM next cycle.
  - Otherwise, if MEM matches: select 10. MEM moves to WB next cycle.
  - Otherwise: select 00.
  - EX has priority over MEM.
- The register file is write-first, so WB-stage writers need no forwarding at ID time.
- Stage update on every clock edge:
  - wb ← mem.
  - mem ← ex.
  - ex ← id (id_valid, id_micro), except when stall or flush is asserted. In that case ex ← bubble: valid 0, micro {INS_NOP, 5'd0}, fwd 00.
- flush and stall together: flush wins. A bubble is inserted, stall reads 0, and the counter does not increment.
- MEM and WB always advance; there is no back-pressure from later stages.
- stall_count increments by 1 on each edge where stall=1 and holds at all-ones.

## Timing
- Reset, asynchronous, on rst_n low:
  - All valid bits 0.
  - All stage micro registers {INS_NOP, 5'd0}.
  - fwd_a/fwd_b 00.
  - stall_count 0.
  - stall therefore reads 0.
- Reset release takes effect at the first rising clk after rst_n goes high.
- stall is combinational from the current ex register and the ID inputs, and is valid in the same cycle.
- fwd_a/fwd_b become valid one cycle after the instruction is in ID, i.e. during its EX cycle, aligned with ex_micro.
- Load-use costs exactly one stall cycle. After the stall the load is in MEM, so the re-presented ID instruction gets fwd 10.
- Back-to-back loads each feeding the next instruction: one stall per pair.
- Reset asserted mid-stall: all state clears immediately, and stall drops without waiting for a clock.

## Test plan
- ADD with rd=5 in ID, then SUB with rs=5, use_rs=1 → no stall; SUB's EX cycle shows fwd_a=01, fwd_b=00.
- LW with rt=8, then ADD with rs=8 → stall=1 for exactly 1 cycle and ex_valid=0 in the bubble; ADD then enters EX with fwd_a=10; stall_count=1.
- ADDI writing r0, then a reader of r0 → no stall, fwd 00. SW with garbage destination, then a reader → no match.
- ADD r3 in MEM and ORI r3 in EX, reader of r3 in both operands → fwd_a=fwd_b=01 (EX priority).
- Load-use hazard with flush=1 in the same cycle → stall=0, bubble inserted, stall_count unchanged.
- Reset pulse on rst_n while a stall is active → all outputs return to reset values asynchronously; after 4 bubbles, stall_count saturation is checked by forcing STALL_CNT_W=2 and running 5 stalls → count holds at 3.
